// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM encoding for the SPI-attached RAM command decoder.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic {
        NO_RADDR = 1'b0,
        RADDR_OK = 1'b1
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// MEM_DEPTH x 8 synchronous single-port RAM with registered read; contents are never reset.
module spi_ram_mem #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI frames into RAM write/read commands and returns read bytes.
// Define SPI_RAM_AUTO_INC_EN to post-increment wr_addr/rd_addr after each access.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 frame_q, frame_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 err_pend_q, err_pend_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q, cmd_err_d;

    logic [1:0]           opcode;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           mem_rdata;

    assign opcode = din[9:8];

    // Stage 1 decodes the frame and accesses the RAM; stage 2 publishes the result.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        frame_d    = rx_valid;
        rd_pend_d  = 1'b0;
        err_pend_d = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = rd_addr_q;

        if (rx_valid) begin
            unique case (opcode)
                OP_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
                OP_WR_DATA: begin
                    mem_we   = ~rst;
                    mem_addr = wr_addr_q;
`ifdef SPI_RAM_AUTO_INC_EN
                    wr_addr_d = wr_addr_q + 1'b1;
`endif
                end
                OP_RD_ADDR: begin
                    rd_addr_d = din[ADDR_SIZE-1:0];
                    state_d   = RADDR_OK;
                end
                OP_RD_DATA: begin
                    if (state_q == RADDR_OK) begin
                        rd_pend_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + 1'b1;
`endif
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        tx_valid_d = frame_q ? rd_pend_q : tx_valid_q;
        dout_d     = rd_pend_q ? mem_rdata : dout_q;
        cmd_err_d  = err_pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NO_RADDR;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            frame_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
            dout_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            frame_q    <= frame_d;
            rd_pend_q  <= rd_pend_d;
            err_pend_q <= err_pend_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (din[7:0]),
        .rdata (mem_rdata)
    );

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed, table-driven bench for spi_ram_ctrl; one table row per clock cycle.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [9:0] IDLE_DIN = 10'h1EE;

    typedef struct {
        logic       rst;
        logic       rxv;
        logic [9:0] din;
        logic [7:0] dout;
        logic       tx;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic v, input logic [9:0] d,
                                input logic [7:0] edout, input logic etx, input logic eerr);
        vec_t t;
        t.rst  = r;
        t.rxv  = v;
        t.din  = d;
        t.dout = edout;
        t.tx   = etx;
        t.err  = eerr;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [9:0] d);
        rst      = r;
        rx_valid = v;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] edout, input logic etx,
                           input logic eerr);
        chk({tag, " dout"}, dout, edout);
        chk({tag, " tx_valid"}, {7'd0, tx_valid}, {7'd0, etx});
        chk({tag, " cmd_err"}, {7'd0, cmd_err}, {7'd0, eerr});
    endtask

    logic [7:0] exp_second;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = IDLE_DIN;

        //   rst   rxv   din        dout   tx    err
        add(1'b1, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 0 reset
        add(1'b1, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 1 reset
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 2 idle, din ignored
        add(1'b0, 1'b1, 10'h300,  8'h00, 1'b0, 1'b0);   // 3 read with no address
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b1);   // 4 cmd_err pulse
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 5 pulse gone
        add(1'b0, 1'b1, 10'h005,  8'h00, 1'b0, 1'b0);   // 6 wr_addr=05
        add(1'b0, 1'b1, 10'h1A5,  8'h00, 1'b0, 1'b0);   // 7 mem[05]=A5
        add(1'b0, 1'b1, 10'h205,  8'h00, 1'b0, 1'b0);   // 8 rd_addr=05
        add(1'b0, 1'b1, 10'h300,  8'h00, 1'b0, 1'b0);   // 9 read
        add(1'b0, 1'b0, IDLE_DIN, 8'hA5, 1'b1, 1'b0);   // 10 data out
        add(1'b0, 1'b0, IDLE_DIN, 8'hA5, 1'b1, 1'b0);   // 11 held
        add(1'b0, 1'b0, IDLE_DIN, 8'hA5, 1'b1, 1'b0);   // 12 held
        add(1'b0, 1'b1, 10'h010,  8'hA5, 1'b1, 1'b0);   // 13 back-to-back start
        add(1'b0, 1'b1, 10'h1FF,  8'hA5, 1'b0, 1'b0);   // 14 tx drops, dout held
        add(1'b0, 1'b1, 10'h210,  8'hA5, 1'b0, 1'b0);   // 15
        add(1'b0, 1'b1, 10'h300,  8'hA5, 1'b0, 1'b0);   // 16
        add(1'b0, 1'b0, IDLE_DIN, 8'hFF, 1'b1, 1'b0);   // 17
        add(1'b0, 1'b1, 10'h033,  8'hFF, 1'b1, 1'b0);   // 18 wr_addr=33
        add(1'b0, 1'b1, 10'h233,  8'hFF, 1'b0, 1'b0);   // 19 rd_addr=33
        add(1'b0, 1'b1, 10'h13C,  8'hFF, 1'b0, 1'b0);   // 20 write then
        add(1'b0, 1'b1, 10'h300,  8'hFF, 1'b0, 1'b0);   // 21 immediate read
        add(1'b0, 1'b0, IDLE_DIN, 8'h3C, 1'b1, 1'b0);   // 22 new data returned
        add(1'b0, 1'b1, 10'h205,  8'h3C, 1'b1, 1'b0);   // 23 rd_addr=05
        add(1'b1, 1'b1, 10'h300,  8'h00, 1'b0, 1'b0);   // 24 rst wins over frame
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 25 dropped frame no effect
        add(1'b0, 1'b1, 10'h300,  8'h00, 1'b0, 1'b0);   // 26 rd_addr was forgotten
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b1);   // 27 cmd_err
        add(1'b0, 1'b0, IDLE_DIN, 8'h00, 1'b0, 1'b0);   // 28
        add(1'b0, 1'b1, 10'h205,  8'h00, 1'b0, 1'b0);   // 29
        add(1'b0, 1'b1, 10'h3AB,  8'h00, 1'b0, 1'b0);   // 30 payload don't-care
        add(1'b0, 1'b0, IDLE_DIN, 8'hA5, 1'b1, 1'b0);   // 31 memory survived reset
        add(1'b0, 1'b1, 10'h000,  8'hA5, 1'b1, 1'b0);   // 32 wr_addr=00
        add(1'b0, 1'b1, 10'h111,  8'hA5, 1'b0, 1'b0);   // 33 mem[00]=11
        add(1'b1, 1'b1, 10'h1EE,  8'h00, 1'b0, 1'b0);   // 34 write under rst dropped
        add(1'b0, 1'b1, 10'h200,  8'h00, 1'b0, 1'b0);   // 35
        add(1'b0, 1'b1, 10'h300,  8'h00, 1'b0, 1'b0);   // 36
        add(1'b0, 1'b0, IDLE_DIN, 8'h11, 1'b1, 1'b0);   // 37

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].rxv, vecs[i].din);
            chk_out($sformatf("vec%0d", i), vecs[i].dout, vecs[i].tx, vecs[i].err);
        end

        // Address post-increment with wrap, back-to-back reads.
`ifdef SPI_RAM_AUTO_INC_EN
        exp_second = 8'h22;
`else
        exp_second = 8'h22;
`endif
        step(1'b1, 1'b0, IDLE_DIN);
        step(1'b0, 1'b1, 10'h0FF);
        step(1'b0, 1'b1, 10'h111);
        step(1'b0, 1'b1, 10'h122);
        step(1'b0, 1'b1, 10'h2FF);
        step(1'b0, 1'b1, 10'h300);
        step(1'b0, 1'b1, 10'h300);
`ifdef SPI_RAM_AUTO_INC_EN
        chk_out("inc first", 8'h11, 1'b1, 1'b0);
`else
        chk_out("inc first", 8'h22, 1'b1, 1'b0);
`endif
        step(1'b0, 1'b0, IDLE_DIN);
        chk_out("inc second", exp_second, 1'b1, 1'b0);

        // Wrap check on write side: location 00 holds 22 only with auto-increment.
        step(1'b0, 1'b1, 10'h200);
        step(1'b0, 1'b1, 10'h300);
        step(1'b0, 1'b0, IDLE_DIN);
`ifdef SPI_RAM_AUTO_INC_EN
        chk_out("wrap mem00", 8'h22, 1'b1, 1'b0);
`else
        chk_out("wrap mem00", 8'h11, 1'b1, 1'b0);
`endif

        // Back-to-back read errors give two separate cmd_err cycles.
        step(1'b1, 1'b0, IDLE_DIN);
        step(1'b0, 1'b1, 10'h300);
        step(1'b0, 1'b1, 10'h300);
        chk_out("err b2b a", 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, IDLE_DIN);
        chk_out("err b2b b", 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, IDLE_DIN);
        chk_out("err b2b c", 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
